// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-memory program loader.
// Holds the RV32 opcodes that the core's control unit decodes, the
// descriptor class encodings, the loader error codes, the loader FSM
// state encoding and the immediate range helpers used by the encoder.
package isa_pkg;

  localparam logic [6:0] OPC_ALU_R     = 7'b0110011;
  localparam logic [6:0] OPC_ALU_I     = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] OPC_JUMP      = 7'b1101111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  typedef enum logic [2:0] {
    CLS_ALU_R     = 3'd0,
    CLS_ALU_I     = 3'd1,
    CLS_BRANCH_EQ = 3'd2,
    CLS_JUMP      = 3'd3,
    CLS_LOAD      = 3'd4,
    CLS_STORE     = 3'd5,
    CLS_END       = 3'd6,
    CLS_ILLEGAL   = 3'd7
  } op_class_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_IMM      = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // True when the 21-bit immediate is a sign extension of its low 12 bits.
  function automatic logic fits_s12(input logic [20:0] v);
    return v[20:11] == {10{v[11]}};
  endfunction

  // True when the 21-bit immediate is a sign extension of its low 13 bits.
  function automatic logic fits_s13(input logic [20:0] v);
    return v[20:12] == {9{v[12]}};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32 instruction encoder.
// Ports:
//   op_class/op_funct/op_rd/op_rs1/op_rs2/op_imm : decoded descriptor
//   enc_word : assembled 32-bit instruction (0 for END / illegal)
//   enc_err  : descriptor cannot be encoded
//   enc_code : reason (illegal class or immediate range/alignment)
module instr_encoder
  import isa_pkg::*;
(
  input  logic        [2:0]  op_class,
  input  logic        [3:0]  op_funct,
  input  logic        [4:0]  op_rd,
  input  logic        [4:0]  op_rs1,
  input  logic        [4:0]  op_rs2,
  input  logic signed [20:0] op_imm,
  output logic        [31:0] enc_word,
  output logic               enc_err,
  output logic        [1:0]  enc_code
);

  logic w_s12;
  logic w_s13;

  assign w_s12 = fits_s12(op_imm);
  assign w_s13 = fits_s13(op_imm);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    enc_code = ERR_NONE;
    case (op_class)
      CLS_ALU_R:
        enc_word = {1'b0, op_funct[3], 5'b0, op_rs2, op_rs1, op_funct[2:0], op_rd, OPC_ALU_R};
      CLS_ALU_I: begin
        enc_word = {op_imm[11:0], op_rs1, op_funct[2:0], op_rd, OPC_ALU_I};
        if (!w_s12) begin
          enc_err  = 1'b1;
          enc_code = ERR_IMM;
        end
      end
      CLS_LOAD: begin
        enc_word = {op_imm[11:0], op_rs1, 3'b010, op_rd, OPC_LOAD};
        if (!w_s12) begin
          enc_err  = 1'b1;
          enc_code = ERR_IMM;
        end
      end
      CLS_STORE: begin
        enc_word = {op_imm[11:5], op_rs2, op_rs1, 3'b010, op_imm[4:0], OPC_STORE};
        if (!w_s12) begin
          enc_err  = 1'b1;
          enc_code = ERR_IMM;
        end
      end
      CLS_BRANCH_EQ: begin
        enc_word = {op_imm[12], op_imm[10:5], op_rs2, op_rs1, 3'b000,
                    op_imm[4:1], op_imm[11], OPC_BRANCH_EQ};
        // Branch offsets are halfword aligned; bit 0 is not encoded.
        if (!w_s13 || op_imm[0]) begin
          enc_err  = 1'b1;
          enc_code = ERR_IMM;
        end
      end
      CLS_JUMP: begin
        enc_word = {op_imm[20], op_imm[10:1], op_imm[11], op_imm[19:12], op_rd, OPC_JUMP};
        if (op_imm[0]) begin
          enc_err  = 1'b1;
          enc_code = ERR_IMM;
        end
      end
      CLS_END: ;
      default: begin
        enc_err  = 1'b1;
        enc_code = ERR_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads encoded instruction words into instruction memory, then releases the core.
// Ports:
//   clk, arst               : clock, asynchronous active-high reset
//   start                   : begins a session at word address 0 (ignored while loading)
//   op_valid/op_ready       : descriptor handshake, ready only while loading
//   op_class..op_imm        : descriptor fields
//   imem_we/addr/wdata      : registered instruction-memory write port
//   busy, done, cpu_enable  : session status; cpu_enable only after a clean END
//   err, err_code           : sticky error flag and reason
//   count                   : words written this session (saturates at 2^ADDR_W)
module imem_program_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic        [2:0]  op_class,
  input  logic        [3:0]  op_funct,
  input  logic        [4:0]  op_rd,
  input  logic        [4:0]  op_rs1,
  input  logic        [4:0]  op_rs2,
  input  logic signed [20:0] op_imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic        [31:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               cpu_enable,
  output logic               err,
  output logic        [1:0]  err_code,
  output logic [ADDR_W:0]    count
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_cpu_en;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic [31:0]       w_word;
  logic              w_enc_err;
  logic [1:0]        w_enc_code;
  logic              w_full;
  logic              w_session;
  logic              w_write;
  logic              w_end;
  logic              w_fault;
  logic [1:0]        w_fault_code;

  instr_encoder u_enc (
    .op_class (op_class),
    .op_funct (op_funct),
    .op_rd    (op_rd),
    .op_rs1   (op_rs1),
    .op_rs2   (op_rs2),
    .op_imm   (op_imm),
    .enc_word (w_word),
    .enc_err  (w_enc_err),
    .enc_code (w_enc_code)
  );

  // MSB of count set means every word of memory has been written.
  assign w_full = r_count[ADDR_W];

  always_comb begin
    w_state_next = r_state;
    w_session    = 1'b0;
    w_write      = 1'b0;
    w_end        = 1'b0;
    w_fault      = 1'b0;
    w_fault_code = ERR_NONE;
    case (r_state)
      ST_LOAD: begin
        if (op_valid) begin
          if (op_class == CLS_END) begin
            w_end        = 1'b1;
            w_state_next = ST_DONE;
          end else if (w_enc_err) begin
            w_fault      = 1'b1;
            w_fault_code = w_enc_code;
            w_state_next = ST_ERROR;
          end else if (w_full) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_OVERFLOW;
            w_state_next = ST_ERROR;
          end else begin
            w_write = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          w_session    = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Write port, counter and status registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
        r_count <= r_count + CNT_ONE;
      end
      if (w_session) begin
        r_count    <= '0;
        r_done     <= 1'b0;
        r_cpu_en   <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (w_end) begin
        r_done   <= 1'b1;
        r_cpu_en <= 1'b1;
      end
      if (w_fault) begin
        r_err      <= 1'b1;
        r_err_code <= w_fault_code;
      end
    end
  end

  assign op_ready   = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD);
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign cpu_enable = r_cpu_en;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign count      = r_count;

endmodule
